down_timer_ctrl: RTL and testbench
==================================

DOWN_TIMER_CTRL -- requirements
Module: down_timer_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the counter and load-value width in bits.
REQ-002 clk  input  1  System clock; all state changes on the rising edge.
REQ-003 rst  input  1  Reset: asynchronous, active-high.
REQ-004 load_val  input  WIDTH  Start value, sampled only on an accepted start.
REQ-005 start  input  1  Start request, level-sampled each rising edge.
REQ-006 pause  input  1  Hold request: freezes count while high.
REQ-007 abort  input  1  Cancels the run: no done pulse.
REQ-008 count  output  WIDTH  Current down-counter value (registered).
REQ-009 busy  output  1  High in RUN and HOLD states.
REQ-010 done  output  1  One-cycle terminal-count pulse (registered).

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, HOLD; busy = (state != IDLE).
REQ-012 In IDLE, start=1 with load_val!=0 SHALL load count<=load_val and reload_reg<=load_val, and SHALL move to RUN on the same edge.
REQ-013 In IDLE, start=1 with load_val==0 SHALL leave the state in IDLE, hold count=0, and assert done for one cycle.
REQ-014 start SHALL be ignored in RUN and HOLD; load_val SHALL NOT affect a run in progress.
REQ-015 Per-edge priority in RUN/HOLD SHALL be abort > pause > decrement.
REQ-016 abort=1 in RUN or HOLD SHALL set count<=0 and state<=IDLE, with done=0.
REQ-017 In RUN, pause=1 SHALL move the state to HOLD with count unchanged on that edge.
REQ-018 In HOLD, pause=1 SHALL keep count unchanged; pause=0 SHALL move the state to RUN with count unchanged on that edge, and decrementing resumes on the next edge.
REQ-019 In RUN with no pause or abort and count>1, count SHALL become count-1.
REQ-020 Terminal edge: in RUN with no pause or abort and count==1, the block SHALL assert done=1 for exactly the following cycle. The count and state behaviour on that edge is defined in REQ-026/REQ-027.
REQ-021 done SHALL be 0 in every cycle not caused by REQ-013 or REQ-020.
REQ-022 Decrement SHALL be modulo 2^WIDTH arithmetic. By construction count never decrements below 0 or wraps to all-ones.
REQ-023 Latency: a start accepted at edge N SHALL produce done high in the cycle after edge N+load_val, provided there is no pause or abort. Each pause cycle, plus one resume cycle, adds to this delay.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, count=0, done=0, busy=0, and reload_reg=0.
REQ-025 Reset asserted mid-run SHALL discard the run with no done pulse. After deassertion the block SHALL wait in IDLE for a new start.

Configuration
REQ-026 The macro DOWN_TIMER_AUTO_RELOAD_EN SHALL be used. When it is defined, the terminal edge SHALL set count<=reload_reg and the state SHALL stay in RUN. The block then issues periodic done pulses every reload_reg cycles, and count never shows 0 until an abort.
REQ-027 When DOWN_TIMER_AUTO_RELOAD_EN is not defined, the terminal edge SHALL set count<=0 and state<=IDLE (one-shot mode), and reload_reg MAY be omitted.

Verification
REQ-028 Basic: rst pulse, then start with load_val=5 -> count 5,4,3,2,1,0 on consecutive edges; done high only in the cycle count first reads 0; busy falls on the same edge.
REQ-029 Pause: load_val=4, pause high for 3 cycles when count=3 -> count holds 3 for 3 cycles plus 1 resume cycle, then 2,1,0; done occurs 4 cycles later than in the unpaused run.
REQ-030 Abort vs pause: load_val=9, assert abort and pause together at count=6 -> count=0, IDLE, done never asserted; a subsequent start with load_val=2 runs normally.
REQ-031 Edge inputs: start with load_val=0 -> single done pulse, busy stays 0. A start issued during a run with a different load_val -> ignored. load_val=15 -> 15 decrements with no wrap.
REQ-032 Async reset: assert rst between clk edges at count=7 -> count=0 and busy=0 before the next edge, with no done pulse.
REQ-033 With DOWN_TIMER_AUTO_RELOAD_EN defined, load_val=3 -> count 3,2,1,3,2,1,... with done every 3rd cycle; abort -> count=0 and IDLE.

Source files
------------

// File: rtl/down_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : down_timer_ctrl_if
//  Description : Control/status bundle for the down_timer_ctrl block.
//                master : the controller that starts/pauses/aborts the timer
//                slave  : the timer itself
//  Signals     : load_val [WIDTH] start value, sampled on an accepted start
//                start             start request (level-sampled)
//                pause             hold request, freezes the count while high
//                abort             cancels a run without a done pulse
//                count    [WIDTH] current down-counter value
//                busy              high while a run is in progress
//                done              one-cycle terminal-count pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface down_timer_ctrl_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             pause;
   logic             abort;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   modport master (
      output load_val,
      output start,
      output pause,
      output abort,
      input  count,
      input  busy,
      input  done
   );

   modport slave (
      input  load_val,
      input  start,
      input  pause,
      input  abort,
      output count,
      output busy,
      output done
   );
endinterface
`default_nettype wire

// File: rtl/down_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : down_timer_ctrl
//  Description : Loadable down-counter timer with pause and abort.
//                A start in IDLE loads load_val and counts down once per
//                clock; the edge that sees count==1 ends the run and
//                produces a one-cycle done pulse.  A zero load value gives
//                an immediate done pulse without leaving IDLE.
//                Per-edge priority while running: abort > pause > decrement.
//  Macro       : DOWN_TIMER_AUTO_RELOAD_EN
//                  defined   - terminal edge reloads the start value and the
//                              timer keeps running (periodic done pulses)
//                  undefined - one-shot: terminal edge returns to IDLE with
//                              count = 0
//  Ports       : clk  in   system clock, rising edge
//                rst  in   asynchronous active-high reset
//                bus  slave modport of down_timer_ctrl_if
//                     (load_val/start/pause/abort in, count/busy/done out)
//  Parameters  : WIDTH - counter and load-value width in bits (default 4);
//                        must match the WIDTH of the connected interface
//  Revision    : 1.0 - initial release
// ============================================================================
module down_timer_ctrl #(
   parameter int WIDTH = 4
) (
   input wire                clk,
   input wire                rst,
   down_timer_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] C_ZERO = '0;
   localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic             r_done;
   logic             w_done_nxt;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
   // Start value of the current run, restored at every terminal edge.
   logic [WIDTH-1:0] r_reload;
   logic [WIDTH-1:0] w_reload_nxt;
`endif

   // -------------------------------------------------------------------------
   // State / datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_count  <= C_ZERO;
         r_done   <= 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
         r_reload <= C_ZERO;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_done   <= w_done_nxt;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
         r_reload <= w_reload_nxt;
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_done_nxt   = 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      w_reload_nxt = r_reload;
`endif

      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.load_val != C_ZERO) begin
                  w_count_nxt  = bus.load_val;
                  w_state_nxt  = ST_RUN;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                  w_reload_nxt = bus.load_val;
`endif
               end else begin
                  // Zero-length run: report completion at once, stay idle.
                  w_count_nxt = C_ZERO;
                  w_done_nxt  = 1'b1;
               end
            end
         end

         ST_RUN: begin
            if (bus.abort) begin
               w_count_nxt = C_ZERO;
               w_state_nxt = ST_IDLE;
            end else if (bus.pause) begin
               w_state_nxt = ST_HOLD;
            end else if (r_count == C_ONE) begin
               // Terminal edge: done is registered, so it shows up in the
               // same cycle as the post-terminal count value.
               w_done_nxt = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
               w_count_nxt = r_reload;
`else
               w_count_nxt = C_ZERO;
               w_state_nxt = ST_IDLE;
`endif
            end else begin
               w_count_nxt = r_count - C_ONE;
            end
         end

         ST_HOLD: begin
            if (bus.abort) begin
               w_count_nxt = C_ZERO;
               w_state_nxt = ST_IDLE;
            end else if (!bus.pause) begin
               // Resume edge only changes state; decrementing restarts on
               // the following edge.
               w_state_nxt = ST_RUN;
            end
         end

         default: begin
            w_count_nxt = C_ZERO;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.count = r_count;
   assign bus.busy  = (r_state != ST_IDLE);
   assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_down_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_down_timer_ctrl
//  Description : Directed self-checking bench for down_timer_ctrl.
//                Outputs are compared as the triple {count, busy, done}.
//                Inputs change and outputs are sampled 1 time unit after
//                each rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_down_timer_ctrl;

   localparam int WIDTH = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   down_timer_ctrl_if #(.WIDTH(WIDTH)) bus ();

   down_timer_ctrl #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      rst          = 1'b0;
      bus.start    = 1'b0;
      bus.pause    = 1'b0;
      bus.abort    = 1'b0;
      bus.load_val = '0;
      #2 rst = 1'b1;
      #1;  // still before the first clock edge
      checks++;
      if ({bus.count, bus.busy, bus.done} !== {4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_async {count,busy,done} got %h exp %h",
                  {bus.count, bus.busy, bus.done}, 6'h00);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({bus.count, bus.busy, bus.done} !== {4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_idle {count,busy,done} got %h exp %h",
                  {bus.count, bus.busy, bus.done}, 6'h00);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_basic();
      int exp_c[6] = '{5, 4, 3, 2, 1, 0};
      bus.load_val = 4'd5;
      bus.start    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         bus.start = 1'b0;
         checks++;
         if ({bus.count, bus.busy, bus.done} !== {4'(exp_c[i]), (i < 5), (i == 5)}) begin
            errors++;
            $display("FAIL basic step %0d {count,busy,done} got %h exp %h", i,
                     {bus.count, bus.busy, bus.done}, {4'(exp_c[i]), (i < 5), (i == 5)});
         end
      end
      tick();
      checks++;
      if ({bus.count, bus.busy, bus.done} !== {4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL basic_after {count,busy,done} got %h exp %h",
                  {bus.count, bus.busy, bus.done}, 6'h00);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_pause();
      int exp_c[7] = '{3, 3, 3, 3, 2, 1, 0};
      bus.load_val = 4'd4;
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      checks++;
      if ({bus.count, bus.busy, bus.done} !== {4'd3, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL pause_pre {count,busy,done} got %h exp %h",
                  {bus.count, bus.busy, bus.done}, {4'd3, 1'b1, 1'b0});
      end
      for (int i = 0; i < 7; i++) begin
         bus.pause = (i < 3);
         tick();
         checks++;
         if ({bus.count, bus.busy, bus.done} !== {4'(exp_c[i]), (i < 6), (i == 6)}) begin
            errors++;
            $display("FAIL pause step %0d {count,busy,done} got %h exp %h", i,
                     {bus.count, bus.busy, bus.done}, {4'(exp_c[i]), (i < 6), (i == 6)});
         end
      end
      bus.pause = 1'b0;
      tick();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_abort();
      bus.load_val = 4'd9;
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 8; k >= 6; k--) begin
         tick();
         checks++;
         if ({bus.count, bus.busy, bus.done} !== {4'(k), 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abort_run {count,busy,done} got %h exp %h",
                     {bus.count, bus.busy, bus.done}, {4'(k), 1'b1, 1'b0});
         end
      end
      bus.abort = 1'b1;
      bus.pause = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.abort = 1'b0;
         bus.pause = 1'b0;
         checks++;
         if ({bus.count, bus.busy, bus.done} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_idle cycle %0d {count,busy,done} got %h exp %h", i,
                     {bus.count, bus.busy, bus.done}, 6'h00);
         end
      end
`ifndef DOWN_TIMER_AUTO_RELOAD_EN
      begin
         int exp_c[4] = '{2, 1, 0, 0};
         bus.load_val = 4'd2;
         bus.start    = 1'b1;
         for (int i = 0; i < 4; i++) begin
            tick();
            bus.start = 1'b0;
            checks++;
            if ({bus.count, bus.busy, bus.done} !== {4'(exp_c[i]), (i < 2), (i == 2)}) begin
               errors++;
               $display("FAIL abort_restart step %0d {count,busy,done} got %h exp %h", i,
                        {bus.count, bus.busy, bus.done}, {4'(exp_c[i]), (i < 2), (i == 2)});
            end
         end
      end
`endif
   endtask

   // -------------------------------------------------------------------------
   task automatic test_zero_load();
      bus.load_val = 4'd0;
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if ({bus.count, bus.busy, bus.done} !== {4'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL zero_load_done {count,busy,done} got %h exp %h",
                  {bus.count, bus.busy, bus.done}, {4'd0, 1'b0, 1'b1});
      end
      tick();
      checks++;
      if ({bus.count, bus.busy, bus.done} !== {4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL zero_load_after {count,busy,done} got %h exp %h",
                  {bus.count, bus.busy, bus.done}, 6'h00);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_ignore_start();
      int exp_c[5] = '{3, 2, 1, 0, 0};
      bus.load_val = 4'd3;
      bus.start    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         // keep requesting a different run while busy, drop it before the
         // terminal edge so no new run is accepted afterwards
         bus.load_val = 4'd7;
         bus.start    = (i < 2);
         checks++;
         if ({bus.count, bus.busy, bus.done} !== {4'(exp_c[i]), (i < 3), (i == 3)}) begin
            errors++;
            $display("FAIL ignore_start step %0d {count,busy,done} got %h exp %h", i,
                     {bus.count, bus.busy, bus.done}, {4'(exp_c[i]), (i < 3), (i == 3)});
         end
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_max_load();
      bus.load_val = 4'd15;
      bus.start    = 1'b1;
      for (int k = 15; k >= 0; k--) begin
         tick();
         bus.start = 1'b0;
         checks++;
         if ({bus.count, bus.busy, bus.done} !== {4'(k), (k != 0), (k == 0)}) begin
            errors++;
            $display("FAIL max_load exp_count %0d {count,busy,done} got %h exp %h", k,
                     {bus.count, bus.busy, bus.done}, {4'(k), (k != 0), (k == 0)});
         end
      end
      tick();
      checks++;
      if ({bus.count, bus.busy, bus.done} !== {4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL max_load_nowrap {count,busy,done} got %h exp %h",
                  {bus.count, bus.busy, bus.done}, 6'h00);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_async_reset();
      bus.load_val = 4'd9;
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.count, bus.busy, bus.done} !== {4'd7, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL async_pre {count,busy,done} got %h exp %h",
                  {bus.count, bus.busy, bus.done}, {4'd7, 1'b1, 1'b0});
      end
      #3 rst = 1'b1;
      #1;  // mid-cycle, no clock edge since rst rose
      checks++;
      if ({bus.count, bus.busy, bus.done} !== {4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset {count,busy,done} got %h exp %h",
                  {bus.count, bus.busy, bus.done}, 6'h00);
      end
      #1 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ({bus.count, bus.busy, bus.done} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_after cycle %0d {count,busy,done} got %h exp %h", i,
                     {bus.count, bus.busy, bus.done}, 6'h00);
         end
      end
   endtask

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
   // -------------------------------------------------------------------------
   task automatic test_auto_reload();
      int exp_c[8] = '{3, 2, 1, 3, 2, 1, 3, 2};
      bus.load_val = 4'd3;
      bus.start    = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         bus.start    = 1'b0;
         bus.load_val = 4'd5;
         checks++;
         if ({bus.count, bus.busy, bus.done} !==
             {4'(exp_c[i]), 1'b1, (i == 3 || i == 6)}) begin
            errors++;
            $display("FAIL auto_reload step %0d {count,busy,done} got %h exp %h", i,
                     {bus.count, bus.busy, bus.done}, {4'(exp_c[i]), 1'b1, (i == 3 || i == 6)});
         end
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      checks++;
      if ({bus.count, bus.busy, bus.done} !== {4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL auto_reload_abort {count,busy,done} got %h exp %h",
                  {bus.count, bus.busy, bus.done}, 6'h00);
      end
      tick();
      checks++;
      if ({bus.count, bus.busy, bus.done} !== {4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL auto_reload_idle {count,busy,done} got %h exp %h",
                  {bus.count, bus.busy, bus.done}, 6'h00);
      end
   endtask
`endif

   // -------------------------------------------------------------------------
   initial begin
      test_reset();
`ifndef DOWN_TIMER_AUTO_RELOAD_EN
      test_basic();
      test_pause();
      test_ignore_start();
      test_max_load();
`else
      test_auto_reload();
`endif
      test_abort();
      test_zero_load();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
